// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - single-channel PWM period / high-time decoder
//
// Samples an asynchronous PWM pin and measures high time and period in
// prescaled ticks (one tick = CLK_DIV clk cycles). Each completed
// rise-fall-rise sequence is published with a one-cycle valid strobe.
// A line that stops toggling while a measurement is in flight raises stuck.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   pwm_in     asynchronous PWM input
//   period     last measured period in ticks
//   high_time  last measured high time in ticks
//   valid      one-cycle strobe, period/high_time updated this cycle
//   stuck      timeout occurred, no complete cycle since
//   level      synchronized pwm_in, tells 0 % from 100 % when stuck
module pwm_capture #(
    parameter int CLK_DIV  = 391,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [CNT_BITS-1:0] period,
    output logic [CNT_BITS-1:0] high_time,
    output logic                valid,
    output logic                stuck,
    output logic                level
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]       PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]       PRE_ONE = PW'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic                sync3_q, sync3_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_BITS-1:0] period_q, period_d;
    logic [CNT_BITS-1:0] high_time_q, high_time_d;
    logic                valid_q, valid_d;
    logic                stuck_q, stuck_d;
    state_t              state_q, state_d;

    logic                tick;
    logic                cnt_sat;
    logic                timeout;
    logic [CNT_BITS-1:0] cnt_inc;

    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
        // Edge strobes are registered so every decision uses a clean pulse.
        rise_d  = sync2_q & ~sync3_q;
        fall_d  = ~sync2_q & sync3_q;

        tick    = (pre_q == PRE_MAX);
        cnt_sat = (cnt_q == CNT_MAX);
        // cnt_inc already includes this cycle's tick, so a capture taken on
        // an edge equals floor(elapsed cycles / CLK_DIV) since the last rise.
        cnt_inc = (tick && !cnt_sat) ? cnt_q + CNT_ONE : cnt_q;
        // An edge in the same cycle as the overflowing tick wins.
        timeout = tick && cnt_sat && !rise_q && !fall_q;

        pre_d       = tick ? '0 : pre_q + PRE_ONE;
        cnt_d       = cnt_inc;
        hi_cap_d    = hi_cap_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        stuck_d     = stuck_q;
        state_d     = state_q;

        if (rise_q) begin
            pre_d = '0;
            cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (rise_q) state_d = HIGH;
            end
            HIGH: begin
                // A rise here just restarts the count (handled above).
                if (fall_q) begin
                    hi_cap_d = cnt_inc;
                    state_d  = LOW;
                end
            end
            LOW: begin
                if (rise_q) begin
                    period_d    = cnt_inc;
                    high_time_d = hi_cap_q;
                    valid_d     = 1'b1;
                    stuck_d     = 1'b0;
                    state_d     = HIGH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && timeout) begin
            period_d    = '0;
            high_time_d = '0;
            valid_d     = 1'b1;
            stuck_d     = 1'b1;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            pre_q       <= '0;
            cnt_q       <= '0;
            hi_cap_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            state_q     <= IDLE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            hi_cap_q    <= hi_cap_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
            state_q     <= state_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;
    assign level     = sync2_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pa = 1'b0, pb = 1'b0, pc = 1'b0;

    logic [15:0] period_a, high_a;
    logic        valid_a, stuck_a, level_a;
    logic [15:0] period_b, high_b;
    logic        valid_b, stuck_b, level_b;
    logic [7:0]  period_c, high_c;
    logic        valid_c, stuck_c, level_c;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pwm_capture #(.CLK_DIV(4), .CNT_BITS(16)) u_a (
        .clk(clk), .rst(rst), .pwm_in(pa), .period(period_a), .high_time(high_a),
        .valid(valid_a), .stuck(stuck_a), .level(level_a)
    );
    pwm_capture #(.CLK_DIV(1), .CNT_BITS(16)) u_b (
        .clk(clk), .rst(rst), .pwm_in(pb), .period(period_b), .high_time(high_b),
        .valid(valid_b), .stuck(stuck_b), .level(level_b)
    );
    pwm_capture #(.CLK_DIV(1), .CNT_BITS(8)) u_c (
        .clk(clk), .rst(rst), .pwm_in(pc), .period(period_c), .high_time(high_c),
        .valid(valid_c), .stuck(stuck_c), .level(level_c)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pa = 1'b0; pb = 1'b0; pc = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if ({period_a, high_a, valid_a, stuck_a, level_a} !== 35'd0)
            $display("FAIL reset_a: got %h expected 0", {period_a, high_a, valid_a, stuck_a, level_a});
        else passed++;
        checks++;
        if ({period_b, high_b, valid_b, stuck_b, level_b} !== 35'd0)
            $display("FAIL reset_b: got %h expected 0", {period_b, high_b, valid_b, stuck_b, level_b});
        else passed++;
        checks++;
        if ({period_c, high_c, valid_c, stuck_c, level_c} !== 19'd0)
            $display("FAIL reset_c: got %h expected 0", {period_c, high_c, valid_c, stuck_c, level_c});
        else passed++;
    endtask

    // 40 high / 60 low at CLK_DIV=4: high_time 10, period 25, strobe 4 cycles after each rise but the first
    task automatic test_div4();
        int nv = 0;
        for (int i = 0; i <= 310; i++) begin
            pa = ((i % 100) < 40);
            step();
            if (valid_a) begin
                nv++;
                checks++;
                if ((i % 100) != 3 || i < 100) $display("FAIL div4_time: valid at %0d expected 103/203/303", i);
                else passed++;
                checks++;
                if (period_a !== 16'd25) $display("FAIL div4_period: got %0d expected 25", period_a);
                else passed++;
                checks++;
                if (high_a !== 16'd10) $display("FAIL div4_high: got %0d expected 10", high_a);
                else passed++;
            end
        end
        checks++;
        if (nv != 3) $display("FAIL div4_count: got %0d expected 3", nv);
        else passed++;
        pa = 1'b0;
        repeat (10) step();
    endtask

    // 1 high / 3 low at CLK_DIV=1: high_time 1, period 4, first strobe 4 cycles after second rise
    task automatic test_div1();
        int nv = 0;
        for (int i = 0; i <= 40; i++) begin
            pb = ((i % 4) == 0);
            step();
            if (valid_b) begin
                nv++;
                checks++;
                if ((i % 4) != 3 || i < 7) $display("FAIL div1_time: valid at %0d expected 7,11,..", i);
                else passed++;
                checks++;
                if (period_b !== 16'd4 || high_b !== 16'd1)
                    $display("FAIL div1_meas: got period %0d high %0d expected 4 1", period_b, high_b);
                else passed++;
            end
        end
        checks++;
        if (nv != 9) $display("FAIL div1_count: got %0d expected 9", nv);
        else passed++;
        pb = 1'b0;
        repeat (10) step();
    endtask

    // CNT_BITS=8: held high after a rise, timeout strobe 260 cycles after the pin rise
    task automatic test_stuck_high();
        int nv = 0;
        for (int i = 0; i <= 280; i++) begin
            pc = 1'b1;
            step();
            if (i == 258) begin
                checks++;
                if (stuck_c !== 1'b0) $display("FAIL stuck_hi_early: got %0b expected 0", stuck_c);
                else passed++;
            end
            if (valid_c) begin
                nv++;
                checks++;
                if (i != 259) $display("FAIL stuck_hi_time: valid at %0d expected 259", i);
                else passed++;
                checks++;
                if ({period_c, high_c, stuck_c, level_c} !== 18'b11)
                    $display("FAIL stuck_hi_out: got p %0d h %0d s %0b l %0b expected 0 0 1 1",
                             period_c, high_c, stuck_c, level_c);
                else passed++;
            end
        end
        checks++;
        if (nv != 1) $display("FAIL stuck_hi_count: got %0d expected 1", nv);
        else passed++;
    endtask

    task automatic test_stuck_low();
        int nv = 0;
        pc = 1'b0;
        repeat (5) step();
        checks++;
        if (stuck_c !== 1'b1 || valid_c !== 1'b0)
            $display("FAIL stuck_idle_hold: got s %0b v %0b expected 1 0", stuck_c, valid_c);
        else passed++;
        for (int j = 0; j <= 280; j++) begin
            pc = (j < 10);
            step();
            if (valid_c) begin
                nv++;
                checks++;
                if (j != 259) $display("FAIL stuck_lo_time: valid at %0d expected 259", j);
                else passed++;
                checks++;
                if ({period_c, high_c, stuck_c, level_c} !== 18'b10)
                    $display("FAIL stuck_lo_out: got p %0d h %0d s %0b l %0b expected 0 0 1 0",
                             period_c, high_c, stuck_c, level_c);
                else passed++;
            end
        end
        checks++;
        if (nv != 1) $display("FAIL stuck_lo_count: got %0d expected 1", nv);
        else passed++;
    endtask

    // 5/5 after stuck: first rise arms, strobe after second rise clears stuck
    task automatic test_resume();
        int nv = 0;
        for (int j = 0; j <= 25; j++) begin
            pc = ((j % 10) < 5);
            step();
            if (j == 12) begin
                checks++;
                if (stuck_c !== 1'b1) $display("FAIL resume_pre_stuck: got %0b expected 1", stuck_c);
                else passed++;
            end
            if (valid_c) begin
                nv++;
                checks++;
                if (j != 13 && j != 23) $display("FAIL resume_time: valid at %0d expected 13/23", j);
                else passed++;
                checks++;
                if (period_c !== 8'd10 || high_c !== 8'd5 || stuck_c !== 1'b0)
                    $display("FAIL resume_out: got p %0d h %0d s %0b expected 10 5 0", period_c, high_c, stuck_c);
                else passed++;
            end
        end
        checks++;
        if (nv != 2) $display("FAIL resume_count: got %0d expected 2", nv);
        else passed++;
        pc = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        for (int j = 0; j <= 15; j++) begin
            pb = (j < 5) || (j >= 10);
            step();
        end
        checks++;
        if (period_b !== 16'd10) $display("FAIL rstmid_pre: got period %0d expected 10", period_b);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        pb = 1'b0;
        checks++;
        if ({period_b, high_b, valid_b, stuck_b, level_b} !== 35'd0)
            $display("FAIL rstmid_clear: got %h expected 0", {period_b, high_b, valid_b, stuck_b, level_b});
        else passed++;
        for (int k = 0; k <= 25; k++) begin
            pb = (k >= 10) && ((k % 10) < 5);
            step();
            if (valid_b) begin
                nv++;
                checks++;
                if (k != 23) $display("FAIL rstmid_time: valid at %0d expected 23", k);
                else passed++;
                checks++;
                if (period_b !== 16'd10 || high_b !== 16'd5)
                    $display("FAIL rstmid_meas: got p %0d h %0d expected 10 5", period_b, high_b);
                else passed++;
            end
        end
        checks++;
        if (nv != 1) $display("FAIL rstmid_count: got %0d expected 1", nv);
        else passed++;
        pb = 1'b0;
        repeat (10) step();
    endtask

    // 30/70 then 70/30: strobe at the change reports 30, the next one 70
    task automatic test_duty_change();
        int nv = 0;
        for (int i = 0; i <= 210; i++) begin
            pb = (i < 30) || (i >= 100 && i < 170) || (i >= 200);
            step();
            if (valid_b && i >= 100) begin
                nv++;
                checks++;
                if (i != 103 && i != 203) $display("FAIL duty_time: valid at %0d expected 103/203", i);
                else passed++;
                checks++;
                if (period_b !== 16'd100 || high_b !== ((i == 103) ? 16'd30 : 16'd70))
                    $display("FAIL duty_meas: at %0d got p %0d h %0d expected 100 %0d",
                             i, period_b, high_b, (i == 103) ? 30 : 70);
                else passed++;
            end
        end
        checks++;
        if (nv != 2) $display("FAIL duty_count: got %0d expected 2", nv);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_div4();
        test_div1();
        test_stuck_high();
        test_stuck_low();
        test_resume();
        test_reset_mid();
        test_duty_change();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
